fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end with a prefetch FIFO.
- Replaces the bare PC register + PC+4 adder + single IF/ID latch in the IF stage of the pipelined MIPS core.
- Generates fetch addresses to the combinational instruction memory and buffers up to DEPTH fetched {inst, pc} entries.
- Delivers them to decode over a valid/ready handshake; a redirect (taken branch or jump resolved downstream) flushes the queue and retargets fetch.

Parameters:
WIDTH, 32, address and instruction width in bits.
DEPTH, 4, FIFO entries; power of two, ≥2.
RESET_PC, 0, fetch PC value after reset.
PC_STEP, 4, fetch PC increment per fetched instruction.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
fetch_en  in  1  fetch permitted this cycle (0 = freeze fetch PC, no push).
imem_addr  out  WIDTH  fetch address to instruction memory; equals fetch PC register.
imem_inst  in  WIDTH  instruction at imem_addr, valid in the same cycle (combinational memory).
redirect  in  1  flush queue and retarget fetch.
redirect_pc  in  WIDTH  new fetch PC; sampled when redirect=1.
out_valid  out  1  head entry valid to decode.
out_ready  in  1  decode accepts head entry.
out_inst  out  WIDTH  head instruction.
out_pc  out  WIDTH  address of head instruction.
out_pcplus4  out  WIDTH  out_pc + PC_STEP, modulo 2^WIDTH.
count  out  clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (rst=0, async, any time): fpc=RESET_PC, rd_ptr=wr_ptr=0, count=0, out_valid=0. Entry storage is not reset; out_inst/out_pc/out_pcplus4 are don't-care while out_valid=0. Mid-operation reset discards all entries with no partial pushes or pops.
- imem_addr = fpc, combinational from the register.
- full = (count==DEPTH); empty = (count==0).
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect & (~full | pop). Pushing while full is allowed only when a pop occurs in the same cycle.
- On push: store {imem_inst, fpc} at wr_ptr; wr_ptr+1 mod DEPTH; fpc += PC_STEP (wraps mod 2^WIDTH, no flag).
- On pop: rd_ptr+1 mod DEPTH.
- count update: +1 on push only, −1 on pop only, unchanged when both or neither occur. Overflow and underflow are impossible by construction.
- out_valid = ~empty & ~redirect. When redirect=1 no transfer occurs regardless of out_ready.
- Head outputs are read combinationally from the rd_ptr entry. out_pcplus4 is computed combinationally.
- Redirect (cycle T): at edge T+1, rd_ptr=wr_ptr=0, count=0, fpc=redirect_pc; no push or pop in T.
  - Target instruction is pushed at edge T+2 and visible with out_valid=1 in cycle T+2 (if fetch_en=1 in T+1).
  - redirect takes priority over fetch_en, push and pop. Back-to-back redirects: the last one wins.
- Latency: empty queue, fetch_en=1 → instruction fetched in cycle N is presented in cycle N+1.
- Steady-state throughput: 1 instruction/cycle with out_ready held at 1.
- Ordering: strictly FIFO in PC order between redirects; pointer wrap-around is transparent.
- fetch_en=0: fpc holds, no push; pops continue normally.

Test Plan:
1. Reset then fetch_en=1, out_ready=1, imem returns addr^0xA5A5A5A5 → out_valid from cycle 1; out_pc sequence 0,4,8,…; out_pcplus4=out_pc+4; count stays 1.
2. out_ready=0 for 6 cycles (DEPTH=4) → count 1,2,3,4,4,4; imem_addr freezes at 0x10; then out_ready=1 → entries drained in order 0x0,0x4,0x8,0xC while refilling, count holds at 4 (push+pop at full).
3. Full queue, redirect=1 with redirect_pc=0x400, out_ready=1 → out_valid=0 that cycle, no pop; next cycle count=0, imem_addr=0x400; following cycle out_pc=0x400, out_valid=1.
4. Redirect on two consecutive cycles (0x100 then 0x200) → only 0x200 stream emerges; no 0x100 entry ever presented.
5. RESET_PC=0xFFFFFFF8, free-running → out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; out_pcplus4 at 0xFFFFFFFC equals 0x0.
6. Assert rst=0 asynchronously mid-cycle with count=3 → out_valid and count drop to 0 immediately; after release imem_addr=RESET_PC and fetch restarts cleanly.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end with a prefetch FIFO.
// Drives the fetch PC to a combinational instruction memory, buffers up to
// DEPTH {inst, pc} entries and hands them to decode over valid/ready.
// A redirect flushes the buffer and retargets the fetch PC.
module fetch_queue #(
    parameter int unsigned           WIDTH    = 32,
    parameter int unsigned           DEPTH    = 4,
    parameter logic [WIDTH-1:0]      RESET_PC = '0,
    parameter logic [WIDTH-1:0]      PC_STEP  = WIDTH'(4)
) (
    input  logic                     clk,
    input  logic                     rst,          // asynchronous, active-low
    input  logic                     fetch_en,
    output logic [WIDTH-1:0]         imem_addr,
    input  logic [WIDTH-1:0]         imem_inst,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_inst,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_pcplus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_fpc;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_inst_mem [DEPTH];
    logic [WIDTH-1:0] r_pc_mem   [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    // Handshake and occupancy decode; redirect blocks every transfer.
    always_comb begin
        w_full    = (r_count == CW'(DEPTH));
        w_empty   = (r_count == '0);
        out_valid = ~w_empty & ~redirect;
        w_pop     = out_valid & out_ready;
        w_push    = fetch_en & ~redirect & (~w_full | w_pop);
    end

    // Fetch PC, pointers and occupancy; redirect overrides push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc    <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_fpc    <= redirect_pc;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fpc    <= r_fpc + PC_STEP;
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage is deliberately left out of reset; validity lives in r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= imem_inst;
            r_pc_mem[r_wr_ptr]   <= r_fpc;
        end
    end

    // Fetch address and head-of-queue outputs.
    always_comb begin
        imem_addr   = r_fpc;
        count       = r_count;
        out_inst    = r_inst_mem[r_rd_ptr];
        out_pc      = r_pc_mem[r_rd_ptr];
        out_pcplus4 = r_pc_mem[r_rd_ptr] + PC_STEP;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: table-driven vectors plus hand-written
// sequences for address wrap and asynchronous mid-cycle reset.
module tb_fetch_queue;

    localparam logic [31:0] XORPAT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;

    logic [31:0] imem_addr, imem_inst, out_inst, out_pc, out_pcplus4;
    logic        out_valid;
    logic [2:0]  count;

    logic [31:0] w_imem_addr, w_imem_inst, w_out_inst, w_out_pc, w_out_pcplus4;
    logic        w_out_valid;
    logic [2:0]  w_count;

    int n_checks = 0;
    int n_fail   = 0;
    int saw_100  = 0;

    always #5 clk = ~clk;

    assign imem_inst   = imem_addr ^ XORPAT;
    assign w_imem_inst = w_imem_addr ^ XORPAT;

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_pcplus4(out_pcplus4),
        .count(count)
    );

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut_w (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(w_imem_addr), .imem_inst(w_imem_inst),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_inst(w_out_inst), .out_pc(w_out_pc), .out_pcplus4(w_out_pcplus4),
        .count(w_count)
    );

    // Any presented entry from the abandoned 0x100 redirect target is an error.
    always @(negedge clk) begin
        if (rst && out_valid && out_pc[31:8] == 24'h000001) saw_100++;
    end

    typedef struct {
        logic        do_rst;
        logic        fe;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [2:0]  ecount;
        logic [31:0] eaddr;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic fe, input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic ev, input logic [2:0] ec,
                       input logic [31:0] ea, input logic [31:0] ep);
        vec_t v;
        v.do_rst = r; v.fe = fe; v.rdy = rdy; v.redir = rd; v.rpc = rpc;
        v.ev = ev; v.ecount = ec; v.eaddr = ea; v.epc = ep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to the next cycle, optionally pulse reset, then drive inputs.
    task automatic cyc(input logic r, input logic fe, input logic rdy,
                       input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        if (r) begin
            rst = 1'b0;
            #1;
            rst = 1'b1;
        end
        fetch_en = fe; out_ready = rdy; redirect = rd; redirect_pc = rpc;
        #1;
    endtask

    initial begin
        // Test 1: free-running fetch with out_ready=1
        add(1,1,1,0,0,        0,0,32'h000, 32'h0);
        add(0,1,1,0,0,        1,1,32'h004, 32'h000);
        add(0,1,1,0,0,        1,1,32'h008, 32'h004);
        add(0,1,1,0,0,        1,1,32'h00C, 32'h008);
        add(0,1,1,0,0,        1,1,32'h010, 32'h00C);
        // Test 2: stall to full, then drain while refilling
        add(1,1,0,0,0,        0,0,32'h000, 32'h0);
        add(0,1,0,0,0,        1,1,32'h004, 32'h000);
        add(0,1,0,0,0,        1,2,32'h008, 32'h000);
        add(0,1,0,0,0,        1,3,32'h00C, 32'h000);
        add(0,1,0,0,0,        1,4,32'h010, 32'h000);
        add(0,1,0,0,0,        1,4,32'h010, 32'h000);
        add(0,1,0,0,0,        1,4,32'h010, 32'h000);
        add(0,1,1,0,0,        1,4,32'h010, 32'h000);
        add(0,1,1,0,0,        1,4,32'h014, 32'h004);
        add(0,1,1,0,0,        1,4,32'h018, 32'h008);
        add(0,1,1,0,0,        1,4,32'h01C, 32'h00C);
        add(0,1,1,0,0,        1,4,32'h020, 32'h010);
        // Test 3: redirect from a full queue
        add(0,1,1,1,32'h400,  0,4,32'h024, 32'h0);
        add(0,1,1,0,0,        0,0,32'h400, 32'h0);
        add(0,1,1,0,0,        1,1,32'h404, 32'h400);
        // Test 4: back-to-back redirects, last wins
        add(0,1,1,1,32'h100,  0,1,32'h408, 32'h0);
        add(0,1,1,1,32'h200,  0,0,32'h100, 32'h0);
        add(0,1,1,0,0,        0,0,32'h200, 32'h0);
        add(0,1,1,0,0,        1,1,32'h204, 32'h200);
        add(0,1,1,0,0,        1,1,32'h208, 32'h204);
        // fetch_en=0 freezes fetch while pops continue
        add(0,0,1,0,0,        1,1,32'h20C, 32'h208);
        add(0,0,1,0,0,        0,0,32'h20C, 32'h0);
        add(0,1,1,0,0,        0,0,32'h20C, 32'h0);
        add(0,1,1,0,0,        1,1,32'h210, 32'h20C);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 32'(out_valid), 32'h0);
        chk("reset count", 32'(count), 32'h0);
        chk("reset addr", imem_addr, 32'h0);
        chk("reset addr wrapdut", w_imem_addr, 32'hFFFF_FFF8);
        rst = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].do_rst, vecs[i].fe, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].ecount));
            chk($sformatf("v%0d addr", i), imem_addr, vecs[i].eaddr);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d pc", i), out_pc, vecs[i].epc);
                chk($sformatf("v%0d inst", i), out_inst, vecs[i].epc ^ XORPAT);
                chk($sformatf("v%0d pcplus4", i), out_pcplus4, vecs[i].epc + 32'd4);
            end
        end
        chk("no 0x100 entry presented", 32'(saw_100), 32'h0);

        // Test 5: address wrap with RESET_PC=0xFFFFFFF8
        begin
            logic [31:0] wpc [4];
            wpc[0] = 32'hFFFF_FFF8; wpc[1] = 32'hFFFF_FFFC; wpc[2] = 32'h0; wpc[3] = 32'h4;
            cyc(1, 1, 1, 0, 0);
            chk("wrap c0 valid", 32'(w_out_valid), 32'h0);
            chk("wrap c0 addr", w_imem_addr, 32'hFFFF_FFF8);
            for (int unsigned k = 0; k < 4; k++) begin
                cyc(0, 1, 1, 0, 0);
                chk($sformatf("wrap c%0d valid", k + 1), 32'(w_out_valid), 32'h1);
                chk($sformatf("wrap c%0d pc", k + 1), w_out_pc, wpc[k]);
                chk($sformatf("wrap c%0d inst", k + 1), w_out_inst, wpc[k] ^ XORPAT);
                chk($sformatf("wrap c%0d pcplus4", k + 1), w_out_pcplus4, wpc[k] + 32'd4);
            end
        end

        // Test 6: asynchronous reset mid-cycle with three entries queued
        cyc(1, 1, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        chk("arst pre count", 32'(count), 32'h3);
        chk("arst pre valid", 32'(out_valid), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst immediate valid", 32'(out_valid), 32'h0);
        chk("arst immediate count", 32'(count), 32'h0);
        chk("arst immediate addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("arst held count", 32'(count), 32'h0);
        chk("arst held addr", imem_addr, 32'h0);
        fetch_en = 1'b0;
        rst = 1'b1;
        cyc(0, 1, 1, 0, 0);
        chk("arst restart c0 valid", 32'(out_valid), 32'h0);
        chk("arst restart c0 addr", imem_addr, 32'h0);
        cyc(0, 1, 1, 0, 0);
        chk("arst restart c1 valid", 32'(out_valid), 32'h1);
        chk("arst restart c1 pc", out_pc, 32'h0);
        chk("arst restart c1 inst", out_inst, XORPAT);
        chk("arst restart c1 count", 32'(count), 32'h1);
        chk("arst restart c1 addr", imem_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
